// File: rtl/seqgen_pkg.sv
// Shared types and constants for the programmable sequence generator:
// run modes, FSM states and the power-on/reset default table contents.
package seqgen_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSVD     = 2'd3
    } seq_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } seq_state_e;

    localparam int SEQ_LEN = 8;

    // Default table contents, repeated cyclically to fill the table depth.
    localparam logic [7:0] DEFAULT_SEQ [SEQ_LEN] = '{
        8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
    };

endpackage

// File: rtl/seqgen_table.sv
// Sequence table: DEPTH x DATA_W registers with a synchronous write port,
// combinational read port and reset to the default sequence.
// Writes are accepted only while the generator is not busy and the
// address lies inside the table.
module seqgen_table
    import seqgen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;

    // Default word for entry i, truncated or zero-extended to DATA_W.
    function automatic logic [DATA_W-1:0] default_word(input int i);
        return DATA_W'(DEFAULT_SEQ[i % SEQ_LEN]);
    endfunction

    // Write qualification: idle generator and in-range address only.
    always_comb begin
        wr_ok = wr_en && !busy && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
    end

    // Table storage: restore the default sequence on reset, else write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= default_word(i);
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/programmable_sequence_generator.sv
// Programmable sequence generator: replays a writable table as a
// valid/ready stream in loop, one-shot or (optionally) ping-pong order.
// Optional feature macro: SEQGEN_PINGPONG_EN enables mode 2 as ping-pong;
// when undefined mode 2 behaves as loop and no direction register exists.
module programmable_sequence_generator
    import seqgen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [ADDR_W:0]   length,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] index,
    output logic              busy,
    output logic              done
);

    seq_state_e        state_q, state_d;
    seq_mode_e         mode_q, mode_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] step_ptr;
    logic              last;
    logic [DATA_W-1:0] rd_data;
`ifdef SEQGEN_PINGPONG_EN
    logic              dir_q, dir_d;     // 0 = counting up, 1 = counting down
    logic              step_dir;
`endif

    seqgen_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (ptr_q),
        .rd_data (rd_data)
    );

    // Pointer successor after a transfer, according to the latched mode.
    always_comb begin
        last     = ({1'b0, ptr_q} == (len_q - (ADDR_W+1)'(1)));
        step_ptr = last ? '0 : ptr_q + ADDR_W'(1);
`ifdef SEQGEN_PINGPONG_EN
        step_dir = dir_q;
        if (mode_q == MODE_PINGPONG) begin
            if (!dir_q) begin
                if (last) begin
                    // Turn around without repeating the top endpoint.
                    if (len_q > (ADDR_W+1)'(1)) begin
                        step_ptr = ptr_q - ADDR_W'(1);
                        step_dir = 1'b1;
                    end else begin
                        step_ptr = '0;
                    end
                end else begin
                    step_ptr = ptr_q + ADDR_W'(1);
                end
            end else begin
                if (ptr_q == '0) begin
                    step_ptr = (len_q > (ADDR_W+1)'(1)) ? ADDR_W'(1) : '0;
                    step_dir = 1'b0;
                end else begin
                    step_ptr = ptr_q - ADDR_W'(1);
                end
            end
        end
`endif
    end

    // Next-state logic for the IDLE/RUN/FINISH controller.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        valid_d = valid_q;
`ifdef SEQGEN_PINGPONG_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                    mode_d  = seq_mode_e'(mode);
                    len_d   = ((length == '0) || (length > (ADDR_W+1)'(DEPTH)))
                              ? (ADDR_W+1)'(DEPTH) : length;
                    valid_d = enable;
`ifdef SEQGEN_PINGPONG_EN
                    dir_d   = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_FINISH;
                    valid_d = 1'b0;
                    ptr_d   = '0;
                end else if (valid_q && out_ready) begin
                    if (mode_q == MODE_ONESHOT && last) begin
                        state_d = ST_FINISH;
                        valid_d = 1'b0;
                        ptr_d   = '0;
                    end else begin
                        // Back-to-back beats unless enable withdraws them.
                        ptr_d   = step_ptr;
                        valid_d = enable;
`ifdef SEQGEN_PINGPONG_EN
                        dir_d   = step_dir;
`endif
                    end
                end else if (!valid_q) begin
                    valid_d = enable;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                ptr_d   = '0;
            end
        endcase
    end

    // Controller registers; reset abandons any run without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LOOP;
            ptr_q   <= '0;
            len_q   <= (ADDR_W+1)'(DEPTH);
            valid_q <= 1'b0;
`ifdef SEQGEN_PINGPONG_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            valid_q <= valid_d;
`ifdef SEQGEN_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Data is the live table entry at the pointer, zero when no beat is held.
    assign out_valid = valid_q;
    assign data      = valid_q ? rd_data : '0;
    assign index     = ptr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);

endmodule

// File: doc/programmable_sequence_generator.md
PROGRAMMABLE_SEQUENCE_GENERATOR -- requirements
Module: programmable_sequence_generator

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the output word width (at least 1).
REQ-002 Parameter DEPTH, default 8, SHALL set the table entries (at least 2); ADDR_W = clog2(DEPTH).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  permits new beats to be presented.
REQ-006 start  in  1  one-cycle request to begin a run.
REQ-007 stop  in  1  one-cycle request to abort a run.
REQ-008 mode  in  2  0=loop, 1=one-shot, 2=ping-pong (only when SEQGEN_PINGPONG_EN is defined), 3=reserved (treated as loop).
REQ-009 length  in  ADDR_W+1  run length; sampled at start.
REQ-010 wr_en / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  table write port.
REQ-011 out_valid  out  1  data holds a beat.
REQ-012 out_ready  in  1  consumer accepts the beat.
REQ-013 data  out  DATA_W  current table entry.
REQ-014 index  out  ADDR_W  table address of data.
REQ-015 busy / done  out  1 / 1  run active / one-cycle end-of-run pulse.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and FINISH.
REQ-017 IDLE->RUN SHALL occur on start; pointer=0; length 0 or >DEPTH SHALL be taken as DEPTH.
REQ-018 The first beat SHALL appear with out_valid=1, data=table[0], index=0 exactly 1 cycle after start is sampled.
REQ-019 A transfer SHALL occur when out_valid and out_ready are both high; only a transfer advances the pointer.
REQ-020 While out_valid=1 and out_ready=0, data and index SHALL be held stable and out_valid SHALL stay high.
REQ-021 With enable=0, no new beat SHALL be presented: any pending beat completes its transfer, then out_valid=0 and the pointer is held; the run resumes at the same pointer when enable=1.
REQ-022 Loop mode: after transferring index length-1, the next index SHALL be 0, with no bubble.
REQ-023 One-shot mode: after transferring index length-1, the FSM SHALL enter FINISH, with out_valid=0 and done=1 for exactly 1 cycle, then return to IDLE.
REQ-024 stop in RUN SHALL force out_valid=0 next cycle and route through FINISH (done pulse); stop together with start in IDLE SHALL be ignored.
REQ-025 start while busy SHALL be ignored.
REQ-026 busy SHALL be 1 in RUN and FINISH, and 0 in IDLE.
REQ-027 Table writes SHALL take effect only when busy=0; writes are ignored when busy=1 or wr_addr>=DEPTH.
REQ-028 A write and a start in the same cycle SHALL commit the write before the first beat is read.

Reset
REQ-029 Reset SHALL immediately force: FSM=IDLE, pointer=0, out_valid=0, data=0, index=0, busy=0, done=0.
REQ-030 Reset SHALL restore every table entry to the default sequence AF,BC,E2,78,FF,E2,0B,8D, repeated cyclically to DEPTH and truncated or zero-extended to DATA_W.
REQ-031 Reset asserted mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-032 With SEQGEN_PINGPONG_EN defined, mode 2 SHALL traverse 0..length-1 then length-2..0, repeating without repeating the endpoints; e.g. length=4 gives 0,1,2,3,2,1,0,1...
REQ-033 Without SEQGEN_PINGPONG_EN, mode 2 SHALL behave as loop mode and the direction register SHALL not exist.

Structure
REQ-034 Package seqgen_pkg SHALL hold the mode and state enumerations and the default-sequence constant array.
REQ-035 Table storage SHALL be a sub-module seqgen_table: DEPTH x DATA_W registers, synchronous write, combinational read, reset-to-default.

Verification
REQ-036 Scenario: reset, mode=0, length=0, out_ready=1, enable=1, start -> data AF,BC,E2,78,FF,E2,0B,8D,AF one beat per cycle, index 0..7,0.
REQ-037 Scenario: loop run, out_ready=0 for 3 cycles while index=2 -> data=E2 and out_valid held high 3 cycles, then 78.
REQ-038 Scenario: mode=1, length=3 -> AF,BC,E2, then done=1 for 1 cycle, then busy=0 and out_valid=0.
REQ-039 Scenario: in IDLE write addr0=55, start -> first data=55; a write to addr1 during RUN is ignored (BC still appears).
REQ-040 Scenario: enable=0 after beat index 4 transfers -> out_valid=0; enable=1 -> resumes with E2 (index 5).
REQ-041 Scenario: reset pulse mid-run at index 5 -> outputs 0 immediately with no done pulse; the next start yields AF (table restored).
